// File: rtl/char_code_encoder.sv
// ASCII-to-code-word encoder for the parity-checking 7-segment display path.
// Encoded words are buffered in a small FIFO and each is held on `code` for HOLD_CYCLES clocks.
module char_code_encoder #(
   parameter int HOLD_CYCLES = 50000000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_char,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [5:0] code,
   output logic       code_valid,
   output logic       bad_char,
   output logic       busy
);

   localparam int CW = $clog2(HOLD_CYCLES) + 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, SHOW} state_t;

   state_t        state, state_nxt;
   logic [5:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [CW-1:0] hold_cnt;
   logic          push, pop;
   logic          fifo_empty, fifo_full;
   logic [4:0]    idx;
   logic [5:0]    enc_word;
   logic          enc_bad;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_CNT);
   assign in_ready   = !fifo_full;
   assign push       = in_valid && in_ready;

   // Letters carry even overall parity; space is a valid blank, anything else gets broken parity.
   always_comb begin
      idx      = '0;
      enc_word = '0;
      enc_bad  = 1'b0;
      if (in_char >= 8'h41 && in_char <= 8'h54) begin
         idx      = 5'(in_char - 8'h41);
         enc_word = {idx, ^idx};
      end else if (in_char >= 8'h61 && in_char <= 8'h74) begin
         idx      = 5'(in_char - 8'h61);
         enc_word = {idx, ^idx};
      end else if (in_char == 8'h20) begin
         enc_word = '1;
      end else begin
         enc_word = 6'b111110;
         enc_bad  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fifo_empty) state_nxt = SHOW;
         SHOW:    if (hold_cnt == '0 && fifo_empty) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pop        = 1'b0;
      code_valid = (state == SHOW);
      busy       = !fifo_empty || (state == SHOW);
      case (state)
         IDLE:    pop = !fifo_empty;
         SHOW:    pop = (hold_cnt == '0) && !fifo_empty;
         default: pop = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= enc_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         hold_cnt <= '0;
         code     <= '0;
         bad_char <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pop) begin
            code     <= mem[rd_ptr];
            hold_cnt <= HOLD_LOAD;
         end else if (state == SHOW && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
         end
         bad_char <= push && enc_bad;
      end
   end

endmodule

// File: tb/tb_char_code_encoder.sv
// Self-checking bench for char_code_encoder: four instances with different hold times,
// expected code words queued at acceptance and compared cycle by cycle while displayed.
module tb_char_code_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_char    [4];
   logic       in_valid   [4];
   logic       in_ready   [4];
   logic [5:0] code       [4];
   logic       code_valid [4];
   logic       bad_char   [4];
   logic       busy       [4];

   int         checks   = 0;
   int         failures = 0;
   logic [5:0] sb [$];
   bit         stall_seen;
   int         bad_cnt = 0;
   int         b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      char_code_encoder #(
         .HOLD_CYCLES(g == 0 ? 3 : g == 1 ? 2 : g == 2 ? 4 : 1),
         .FIFO_DEPTH (4)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_char   (in_char[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .code      (code[g]),
         .code_valid(code_valid[g]),
         .bad_char  (bad_char[g]),
         .busy      (busy[g])
      );
   end

   always @(negedge clk) if (bad_char[1] === 1'b1) bad_cnt++;

   function automatic logic [5:0] enc(input logic [7:0] c);
      logic [4:0] i;
      if (c >= 8'd65 && c <= 8'd84)       i = 5'(c - 8'd65);
      else if (c >= 8'd97 && c <= 8'd116) i = 5'(c - 8'd97);
      else if (c == 8'd32)                return 6'b111111;
      else                                return 6'b111110;
      return {i, ^i};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Holds each character on the bus until accepted; queues its expected word at the accepting edge.
   task automatic drive_chars(input int d, input string s);
      int guard;
      bit acc;
      for (int i = 0; i < s.len(); i++) begin
         guard       = 0;
         acc         = 1'b0;
         in_char[d]  = s[i];
         in_valid[d] = 1'b1;
         while (!acc && guard < 200) begin
            @(negedge clk);
            if (in_ready[d] === 1'b1) acc = 1'b1;
            else begin
               stall_seen = 1'b1;
               guard++;
            end
         end
         if (!acc) begin
            checks++;
            failures++;
            $error("FAIL accept_timeout observed=stalled expected=accepted");
            in_valid[d] = 1'b0;
            return;
         end
         @(posedge clk);
         sb.push_back(enc(s[i]));
         #1;
         chk("bad_char", bad_char[d], 8'(enc(s[i]) == 6'b111110));
      end
      in_valid[d] = 1'b0;
   endtask

   // Waits at most `bound` cycles for the first word, then expects n words back-to-back.
   task automatic drain(input int d, input int hold, input int n, input int bound);
      int w;
      logic [5:0] exp;
      exp = '0;
      w   = 0;
      while (code_valid[d] !== 1'b1 && w < bound) begin
         @(posedge clk); #1;
         w++;
      end
      for (int k = 0; k < n; k++) begin
         chk("sb_nonempty", 8'(sb.size() != 0), 8'd1);
         if (sb.size() == 0) return;
         exp = sb.pop_front();
         for (int h = 0; h < hold; h++) begin
            chk("code_valid", code_valid[d], 8'd1);
            chk("code", code[d], exp);
            @(posedge clk); #1;
         end
      end
      chk("valid_end", code_valid[d], 8'd0);
      chk("code_kept", code[d], exp);
   endtask

   initial begin
      rst_n = 1'b0;
      stall_seen = 1'b0;
      for (int d = 0; d < 4; d++) begin
         in_char[d]  = 8'h00;
         in_valid[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
         chk("rst_code", code[d], 8'h00);
         chk("rst_valid", code_valid[d], 8'd0);
         chk("rst_bad", bad_char[d], 8'd0);
         chk("rst_busy", busy[d], 8'd0);
         chk("rst_ready", in_ready[d], 8'd1);
      end

      // 1: single 'A', hold 3, word appears one edge after acceptance
      drive_chars(0, "A");
      chk("t1_not_yet_valid", code_valid[0], 8'd0);
      chk("t1_busy_queued", busy[0], 8'd1);
      @(posedge clk); #1;
      drain(0, 3, 1, 0);
      chk("t1_busy_end", busy[0], 8'd0);

      // 2: "BHT" back-to-back, hold 2, no stall
      stall_seen = 1'b0;
      fork
         drive_chars(1, "BHT");
         drain(1, 2, 3, 3);
      join
      chk("t2_no_stall", 8'(stall_seen), 8'd0);
      chk("t2_busy_end", busy[1], 8'd0);

      // 3: lowercase, blank, unsupported
      b0 = bad_cnt;
      fork
         drive_chars(1, "c #");
         drain(1, 2, 3, 3);
      join
      chk("t3_bad_pulses", 8'(bad_cnt - b0), 8'd1);

      // 4: six chars into depth 4 with hold 4: fill, stall, wrap
      stall_seen = 1'b0;
      fork
         drive_chars(2, "ABCDEF");
         drain(2, 4, 6, 3);
      join
      chk("t4_stalled", 8'(stall_seen), 8'd1);
      chk("t4_busy_end", busy[2], 8'd0);

      // 5: reset mid-hold with three words queued
      drive_chars(2, "GHIJ");
      chk("t5_showing", code[2], 8'(enc(8'h47)));
      chk("t5_valid", code_valid[2], 8'd1);
      chk("t5_busy", busy[2], 8'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_code", code[2], 8'h00);
      chk("t5_rst_valid", code_valid[2], 8'd0);
      chk("t5_rst_busy", busy[2], 8'd0);
      chk("t5_rst_bad", bad_char[2], 8'd0);
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t5_ready", in_ready[2], 8'd1);
      chk("t5_idle", code_valid[2], 8'd0);
      drive_chars(2, "E");
      @(posedge clk); #1;
      drain(2, 4, 1, 0);
      chk("t5_no_stale", busy[2], 8'd0);

      // 6: hold 1, one word per cycle
      fork
         drive_chars(3, "ABCDEFGHIJKLMNOPQRST");
         drain(3, 1, 20, 3);
      join
      chk("t6_busy_end", busy[3], 8'd0);
      chk("sb_empty", 8'(sb.size()), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/char_code_encoder.md
Name: char_code_encoder

Overview:
- Transmit-side counterpart of the 7-segment parity-checking display decoder.
- Accepts ASCII characters over a valid/ready handshake and encodes each as a 6-bit code word: {5-bit letter index, parity bit}.
- Buffers encoded words in a small FIFO and presents each word on a parallel bus for a programmable hold time, then advances to the next.
- Drives the decoder's code input directly; sits between the character source (UART/ROM sequencer) and the display path.

Parameters:
- HOLD_CYCLES, 50000000: clock cycles each code word is held on the output. Legal range ≥ 1. The counter width is $clog2(HOLD_CYCLES)+1.
- FIFO_DEPTH, 4: number of encoded words buffered. Must be a power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_char  in  8  ASCII character.
- in_valid  in  1  in_char is valid.
- in_ready  out  1  FIFO can accept a character; equals !full (combinational).
- code  out  6  code word: [5:1] letter index, [0] parity.
- code_valid  out  1  code is currently being displayed.
- bad_char  out  1  one-cycle pulse: an unsupported character was accepted.
- busy  out  1  FIFO non-empty or in SHOW state.

Behaviour:
- Reset: rst_n low asynchronously clears all state:
  - FIFO empty; state = IDLE; hold counter = 0.
  - code = 6'b000000, code_valid = 0, bad_char = 0, busy = 0.
  - in_ready = 1 once reset is released.
  - Reset asserted mid-hold discards all buffered and displayed words; nothing is replayed after reset.
- Handshake:
  - A character is accepted on a rising edge where in_valid && in_ready.
  - in_char must stay stable while in_valid is high and in_ready is low.
- Encoding (on write into the FIFO; the FIFO stores 6-bit words):
  - 'A'..'T' (0x41..0x54) and 'a'..'t' (0x61..0x74) map to index 0..19.
  - code = {idx, ^idx}, so the parity bit equals the XOR of the index bits.
  - Space (0x20) encodes as 6'b111111: index 31 with correct parity, which the decoder shows as blank.
  - Any other value encodes as 6'b111110: deliberately wrong parity, which the decoder shows as its error pattern. bad_char goes high for exactly the cycle following the accepting edge.
- FSM states: IDLE, SHOW.
  - IDLE: if the FIFO is non-empty, pop the head into code, set code_valid = 1, load counter = HOLD_CYCLES-1, and go to SHOW. Otherwise stay in IDLE with code_valid = 0.
  - SHOW, counter ≠ 0: decrement the counter.
  - SHOW, counter = 0 and FIFO non-empty: pop the next word back-to-back. code_valid stays high with no gap cycle; reload the counter.
  - SHOW, counter = 0 and FIFO empty: code_valid = 0 and go to IDLE. code keeps its last value.
- Latency:
  - Character accepted at edge E with the FSM idle: code and code_valid update at edge E+1.
  - Each word is valid for exactly HOLD_CYCLES cycles.
  - With HOLD_CYCLES = 1, a new word can appear every cycle.
- FIFO rules:
  - A push and a pop in the same cycle are both honoured, and the occupancy is unchanged.
  - When full, in_ready = 0 and no write occurs. A pop in that cycle raises in_ready in the next cycle.
  - A pop is never issued while empty.
  - Pointers wrap modulo FIFO_DEPTH. A separate count or an extra pointer bit distinguishes full from empty.
- busy = (FIFO count ≠ 0) || (state == SHOW).

Test Plan:
1. Reset, then push 'A' with HOLD_CYCLES=3 → code=000000 and code_valid=1 from edge E+1 for 3 cycles; then code_valid=0, code still 000000, busy=0.
2. Push "BHT" back-to-back with HOLD_CYCLES=2 → code = 000011, 001111, 100111, each for 2 cycles with no gap; in_ready stays 1.
3. Push 'c', ' ', '#' → code = 000101, then 111111, then 111110; bad_char pulses once, only for '#'.
4. With HOLD_CYCLES=4 and FIFO_DEPTH=4, hold in_valid high with 6 chars → in_ready drops after the FIFO fills. Stalled chars are accepted as words drain, and all 6 are displayed in order. Verifies full-boundary push/pop and pointer wrap-around.
5. Assert rst_n low mid-SHOW with 3 words queued → outputs clear immediately (async) and in_ready=1 after release. After release, push 'E' → code=001001 at the next edge and no stale words appear.
6. HOLD_CYCLES=1, stream 'A'..'T' → one word per cycle, each word's parity bit equals the XOR of its index bits, and code_valid stays high continuously.
